// File: rtl/lab3_sys_mem_tester_pkg.sv
// Shared definitions for the memory tester: FSM state encoding, LFSR taps and default parameters.
package lab3_sys_mem_tester_pkg;

    localparam int DEF_ADDR_W       = 14;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_DEPTH        = 10000;
    localparam int DEF_READ_LATENCY = 1;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ_REQ  = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Right-shifting Galois LFSR: the bit shifted out decides whether the taps are folded back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic [31:0] shifted;
        shifted = {1'b0, v[31:1]};
        if (v[0]) begin
            return shifted ^ LFSR_TAPS;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/lab3_sys_mem_tester_pattern.sv
// Test pattern generator: load restarts the sequence from seed, step advances one word.
// Define LAB3_SYS_MEM_TESTER_LFSR_EN for the LFSR sequence; the default is seed + index.
module lab3_sys_mem_tester_pattern
    import lab3_sys_mem_tester_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] value
);

`ifdef LAB3_SYS_MEM_TESTER_LFSR_EN
    logic [31:0] lfsr_r;
    logic [31:0] seed32_s;

    assign seed32_s = 32'(seed);

    // LFSR state; an all-zero seed would lock up, so it is replaced by 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r <= 32'd0;
        end else if (load) begin
            lfsr_r <= (seed32_s == 32'd0) ? 32'd1 : seed32_s;
        end else if (step) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign value = DATA_W'(lfsr_r);
`else
    logic [DATA_W-1:0] value_r;

    // Incrementing pattern counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= {DATA_W{1'b0}};
        end else if (load) begin
            value_r <= seed;
        end else if (step) begin
            value_r <= value_r + DATA_W'(1);
        end
    end

    assign value = value_r;
`endif

endmodule

// File: rtl/lab3_sys_mem_tester.sv
// Avalon-MM memory tester: writes a pattern over a wrapped address window, reads it back and counts mismatches.
// Optional LFSR pattern via LAB3_SYS_MEM_TESTER_LFSR_EN (see lab3_sys_mem_tester_pattern).
module lab3_sys_mem_tester
    import lab3_sys_mem_tester_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] count,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic              m_read,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_waitrequest
);

    localparam int                LAT_W     = 8;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] count_r;
    logic [ADDR_W-1:0] index_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] first_err_r;
    logic [DATA_W-1:0] seed_r;
    logic [15:0]       err_r;
    logic [LAT_W-1:0]  lat_r;
    logic              busy_r;
    logic              done_r;
    logic              pass_r;
    logic              cs_r;
    logic              wr_r;
    logic              rd_r;

    logic              last_s;
    logic              lat_done_s;
    logic              mismatch_s;
    logic [ADDR_W-1:0] addr_inc_s;
    logic [ADDR_W-1:0] base_wrap_s;
    logic              pat_load_s;
    logic              pat_step_s;
    logic [DATA_W-1:0] pat_seed_s;
    logic [DATA_W-1:0] pat_value_s;

    lab3_sys_mem_tester_pattern #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .clk   (clk),
        .reset (reset),
        .load  (pat_load_s),
        .step  (pat_step_s),
        .seed  (pat_seed_s),
        .value (pat_value_s)
    );

    // Beat bookkeeping and modulo-DEPTH address arithmetic.
    always_comb begin
        last_s      = (index_r == (count_r - ADDR_ONE));
        lat_done_s  = (lat_r == LAT_LAST);
        mismatch_s  = (m_readdata != pat_value_s);
        base_wrap_s = ADDR_W'(32'(base) % DEPTH);
        if (addr_r == ADDR_LAST) begin
            addr_inc_s = ADDR_ZERO;
        end else begin
            addr_inc_s = addr_r + ADDR_ONE;
        end
    end

    // Pattern generator control: restart on launch and again before the read-back phase.
    always_comb begin
        pat_load_s = 1'b0;
        pat_step_s = 1'b0;
        pat_seed_s = seed_r;
        case (state_r)
            ST_IDLE: begin
                pat_seed_s = seed;
                pat_load_s = start;
            end
            ST_WRITE: begin
                if (!m_waitrequest) begin
                    pat_load_s = last_s;
                    pat_step_s = !last_s;
                end else begin
                    pat_load_s = 1'b0;
                end
            end
            ST_READ_WAIT: begin
                if (lat_done_s && !last_s) begin
                    pat_step_s = 1'b1;
                end else begin
                    pat_step_s = 1'b0;
                end
            end
            default: begin
                pat_load_s = 1'b0;
            end
        endcase
    end

    // Main sequencer; every bus strobe and status output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            base_r      <= ADDR_ZERO;
            count_r     <= ADDR_ZERO;
            index_r     <= ADDR_ZERO;
            addr_r      <= ADDR_ZERO;
            first_err_r <= ADDR_ZERO;
            seed_r      <= {DATA_W{1'b0}};
            err_r       <= 16'd0;
            lat_r       <= {LAT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            cs_r        <= 1'b0;
            wr_r        <= 1'b0;
            rd_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        base_r      <= base_wrap_s;
                        count_r     <= count;
                        seed_r      <= seed;
                        index_r     <= ADDR_ZERO;
                        err_r       <= 16'd0;
                        first_err_r <= ADDR_ZERO;
                        if (count == ADDR_ZERO) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            pass_r  <= 1'b1;
                        end else begin
                            state_r <= ST_WRITE;
                            busy_r  <= 1'b1;
                            cs_r    <= 1'b1;
                            wr_r    <= 1'b1;
                            addr_r  <= base_wrap_s;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!m_waitrequest) begin
                        if (last_s) begin
                            state_r <= ST_READ_REQ;
                            index_r <= ADDR_ZERO;
                            wr_r    <= 1'b0;
                            rd_r    <= 1'b1;
                            addr_r  <= base_r;
                        end else begin
                            index_r <= index_r + ADDR_ONE;
                            addr_r  <= addr_inc_s;
                        end
                    end
                end
                ST_READ_REQ: begin
                    if (!m_waitrequest) begin
                        state_r <= ST_READ_WAIT;
                        cs_r    <= 1'b0;
                        rd_r    <= 1'b0;
                        lat_r   <= {LAT_W{1'b0}};
                    end
                end
                ST_READ_WAIT: begin
                    if (lat_done_s) begin
                        // Address is still held from the request, so it names the failing word.
                        if (mismatch_s) begin
                            if (err_r != 16'hFFFF) begin
                                err_r <= err_r + 16'd1;
                            end
                            if (err_r == 16'd0) begin
                                first_err_r <= addr_r;
                            end
                        end
                        if (last_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            pass_r  <= (err_r == 16'd0) && !mismatch_s;
                        end else begin
                            state_r <= ST_READ_REQ;
                            index_r <= index_r + ADDR_ONE;
                            addr_r  <= addr_inc_s;
                            cs_r    <= 1'b1;
                            rd_r    <= 1'b1;
                        end
                    end else begin
                        lat_r <= lat_r + LAT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    cs_r    <= 1'b0;
                    wr_r    <= 1'b0;
                    rd_r    <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_count      = err_r;
    assign first_err_addr = first_err_r;
    assign m_address      = addr_r;
    assign m_byteenable   = cs_r ? 4'hF : 4'h0;
    assign m_chipselect   = cs_r;
    assign m_write        = wr_r;
    assign m_read         = rd_r;
    assign m_writedata    = pat_value_s;

endmodule

// File: tb/tb_lab3_sys_mem_tester.sv
// Self-checking bench for lab3_sys_mem_tester: Avalon RAM model with stalls and fault injection,
// plus a reference model of the expected access sequence and result.
module tb_lab3_sys_mem_tester;

    localparam int DEPTH = 10000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] base = 14'd0;
    logic [13:0] count = 14'd0;
    logic [31:0] seed = 32'd0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [13:0] first_err_addr, m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect, m_write, m_read;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = 32'd0;
    logic        m_waitrequest = 1'b0;

    int n_total = 0;
    int n_bad = 0;

    // RAM model state
    logic [31:0] mem [0:DEPTH-1];
    int          stall_n = 0;
    int          stall_ctr = 0;
    bit          fault_en = 1'b0;
    logic [13:0] fault_addr = 14'd0;
    bit          prev_cs = 1'b0;
    bit          rd_pend = 1'b0;
    logic [31:0] rd_pend_data = 32'd0;
    logic [13:0] hold_addr = 14'd0;
    logic [31:0] hold_wdata = 32'd0;
    int          cs_cycles = 0;
    int          be_err = 0;
    int          stab_err = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] rd_addr_q[$];

    lab3_sys_mem_tester dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base           (base),
        .count          (count),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .m_address      (m_address),
        .m_byteenable   (m_byteenable),
        .m_chipselect   (m_chipselect),
        .m_write        (m_write),
        .m_read         (m_read),
        .m_writedata    (m_writedata),
        .m_readdata     (m_readdata),
        .m_waitrequest  (m_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] s, input int i);
        logic [31:0] v;
`ifdef LAB3_SYS_MEM_TESTER_LFSR_EN
        v = (s == 32'd0) ? 32'd1 : s;
        for (int k = 0; k < i; k++) begin
            if (v[0]) v = (v >> 1) ^ 32'h8020_0003;
            else      v = v >> 1;
        end
`else
        v = s + 32'(i);
`endif
        return v;
    endfunction

    // RAM model: decides waitrequest for the next edge, records accepted beats, returns read data one cycle late.
    always @(negedge clk) begin
        if (rd_pend) begin
            m_readdata = rd_pend_data;
            rd_pend = 1'b0;
        end else begin
            m_readdata = $urandom;
        end
        if (m_chipselect) begin
            cs_cycles++;
            if (m_byteenable != 4'hF) be_err++;
            if (prev_cs && m_waitrequest && (m_address != hold_addr || m_writedata != hold_wdata)) stab_err++;
            hold_addr = m_address;
            hold_wdata = m_writedata;
            if (stall_ctr < stall_n) begin
                m_waitrequest = 1'b1;
                stall_ctr++;
            end else begin
                m_waitrequest = 1'b0;
                stall_ctr = 0;
                if (m_write) begin
                    mem[m_address] = m_writedata;
                    wr_addr_q.push_back(32'(m_address));
                    wr_data_q.push_back(m_writedata);
                end else if (m_read) begin
                    rd_addr_q.push_back(32'(m_address));
                    rd_pend = 1'b1;
                    rd_pend_data = (fault_en && m_address == fault_addr) ? 32'h0000_DEAD : mem[m_address];
                end
            end
        end else begin
            m_waitrequest = 1'b0;
            stall_ctr = 0;
        end
        prev_cs = m_chipselect;
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        cs_cycles = 0;
        be_err = 0;
        stab_err = 0;
    endtask

    task automatic run_test(input logic [13:0] b, input logic [13:0] c, input logic [31:0] s,
                            input bit flt, input logic [13:0] fa, input int stalls, input bit mid);
        int exp_err, done_cyc, busy_bad;
        logic [13:0] exp_first;
        logic [31:0] a, rv;
        stall_n = stalls;
        fault_en = flt;
        fault_addr = fa;
        clear_logs();
        exp_err = 0;
        exp_first = 14'd0;
        for (int i = 0; i < int'(c); i++) begin
            a = 32'((int'(b) + i) % DEPTH);
            rv = (flt && a[13:0] == fa) ? 32'h0000_DEAD : pat(s, i);
            if (rv != pat(s, i)) begin
                if (exp_err == 0) exp_first = a[13:0];
                exp_err++;
            end
        end
        @(posedge clk); #1;
        base = b; count = c; seed = s; start = 1'b1;
        done_cyc = 0;
        busy_bad = 0;
        for (int cyc = 2; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 2) start = 1'b0;
            if (mid && cyc == 8) begin
                start = 1'b1; base = 14'd77; count = 14'd2; seed = 32'h0000_FFFF;
            end
            if (mid && cyc == 9) start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        check_eq("done_seen", 32'(done_cyc != 0), 32'd1);
        check_eq("busy_at_done", 32'(busy), 32'd0);
        check_eq("err_count", 32'(err_count), 32'(exp_err));
        check_eq("first_err_addr", 32'(first_err_addr), 32'(exp_first));
        check_eq("pass", 32'(pass), 32'(exp_err == 0));
        check_eq("busy_during_run", 32'(busy_bad), 32'd0);
        if (c == 14'd0) begin
            check_eq("zero_count_done_cycle", 32'(done_cyc), 32'd2);
            check_eq("zero_count_cs_cycles", 32'(cs_cycles), 32'd0);
        end
        @(posedge clk); #1;
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("pass_hold", 32'(pass), 32'(exp_err == 0));
        check_eq("cs_idle", 32'(m_chipselect), 32'd0);
        check_eq("write_beats", 32'(wr_addr_q.size()), 32'(c));
        check_eq("read_beats", 32'(rd_addr_q.size()), 32'(c));
        for (int i = 0; i < int'(c) && i < wr_addr_q.size(); i++) begin
            check_eq("write_addr", wr_addr_q[i], 32'((int'(b) + i) % DEPTH));
            check_eq("write_data", wr_data_q[i], pat(s, i));
        end
        for (int i = 0; i < int'(c) && i < rd_addr_q.size(); i++) begin
            check_eq("read_addr", rd_addr_q[i], 32'((int'(b) + i) % DEPTH));
        end
        check_eq("byteenable", 32'(be_err), 32'd0);
        check_eq("stall_stability", 32'(stab_err), 32'd0);
    endtask

    task automatic reset_mid_run();
        bool_loop: begin end
        stall_n = 0;
        fault_en = 1'b0;
        clear_logs();
        @(posedge clk); #1;
        base = 14'd100; count = 14'd8; seed = 32'h0000_5000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (wr_addr_q.size() == 1 && m_chipselect && m_write) break;
            @(posedge clk); #1;
        end
        check_eq("second_beat_on_bus", 32'(wr_addr_q.size() == 1 && m_chipselect && m_write), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_cs", 32'(m_chipselect), 32'd0);
        check_eq("rst_write", 32'(m_write), 32'd0);
        check_eq("rst_read", 32'(m_read), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        clear_logs();
        begin
            int done_seen;
            done_seen = 0;
            for (int cyc = 0; cyc < 20; cyc++) begin
                @(posedge clk); #1;
                if (done) done_seen++;
            end
            check_eq("abort_no_done", 32'(done_seen), 32'd0);
            check_eq("abort_no_cs", 32'(cs_cycles), 32'd0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [13:0] rb, rc, rfa;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_pass", 32'(pass), 32'd0);
        check_eq("reset_err", 32'(err_count), 32'd0);
        check_eq("reset_first_err", 32'(first_err_addr), 32'd0);
        check_eq("reset_cs", 32'(m_chipselect), 32'd0);
        check_eq("reset_write", 32'(m_write), 32'd0);
        check_eq("reset_read", 32'(m_read), 32'd0);
        check_eq("reset_address", 32'(m_address), 32'd0);
        check_eq("reset_writedata", m_writedata, 32'd0);
        reset = 1'b0;

        run_test(14'd0, 14'd4, 32'h0000_0100, 1'b0, 14'd0, 0, 1'b0);
        run_test(14'd0, 14'd4, 32'h0000_0100, 1'b1, 14'd2, 0, 1'b0);
        run_test(14'd9998, 14'd4, 32'h1234_0000, 1'b0, 14'd0, 0, 1'b0);
        run_test(14'd50, 14'd0, 32'h0000_0007, 1'b0, 14'd0, 0, 1'b0);
        run_test(14'd0, 14'd4, 32'h0000_0100, 1'b0, 14'd0, 3, 1'b1);
        reset_mid_run();
        run_test(14'd9999, 14'd3, 32'hFFFF_FFFE, 1'b1, 14'd0, 1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            rb = 14'($urandom_range(0, DEPTH - 1));
            rc = 14'($urandom_range(1, 12));
            rfa = 14'((int'(rb) + int'($urandom_range(0, int'(rc) - 1))) % DEPTH);
            run_test(rb, rc, $urandom, 1'($urandom_range(0, 1)), rfa, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
